// File: rtl/cpu_trace_checker.sv
// Golden-trace checker: compares each CPU commit record (pc, instr, regfile0..31) with a golden ROM.
// Optional macro TRACE_CHK_STOP_ON_FAIL_EN freezes the CPU after the first failing record.
module cpu_trace_checker #(
   parameter int unsigned NUM_RECS = 1024,
   parameter int unsigned GOLD_AW  = 16
) (
   input  logic               clk_in,
   input  logic               reset,
   input  logic               chk_en,
   input  logic               commit,
   input  logic [31:0]        pc,
   input  logic [31:0]        inst,
   output logic               hold,
   output logic [4:0]         dbg_raddr,
   input  logic [31:0]        dbg_rdata,
   output logic [GOLD_AW-1:0] gold_addr,
   input  logic [31:0]        gold_rdata,
   output logic [15:0]        rec_cnt,
   output logic               done,
   output logic               mismatch,
   output logic [15:0]        fail_rec,
   output logic [5:0]         fail_idx,
   output logic [31:0]        fail_exp,
   output logic [31:0]        fail_act
);
   localparam logic [5:0]  KLast    = 6'd34;
   localparam logic [15:0] RecLimit = 16'(NUM_RECS);

`ifdef TRACE_CHK_STOP_ON_FAIL_EN
   typedef enum logic [1:0] {StIdle, StCmp, StDone, StFail} state_e;
`else
   typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;
`endif

   state_e             r_state, w_state_d;
   logic [5:0]         r_k, w_k_d;
   logic               r_hold, w_hold_d;
   logic [GOLD_AW-1:0] r_rec_base, w_rec_base_d;
   logic [15:0]        r_rec_cnt, w_rec_cnt_d, w_rec_cnt_inc;
   logic [31:0]        r_pc_sh, r_inst_sh;
   logic               r_mismatch;
   logic [15:0]        r_fail_rec;
   logic [5:0]         r_fail_idx;
   logic [31:0]        r_fail_exp, r_fail_act;

   logic [5:0]         w_j;
   logic [31:0]        w_act;
   logic               w_start, w_cmp_vld, w_diff, w_first;

   // Golden data arrives one cycle after its address, so cycle k checks word k-1.
   assign w_j       = r_k - 6'd1;
   assign w_cmp_vld = (r_state == StCmp) && (r_k != 6'd0);
   assign w_start   = (r_state == StIdle) && commit && chk_en;

   always_comb begin
      w_act = dbg_rdata;
      if (w_j == 6'd0) begin
         w_act = r_pc_sh;
      end else if (w_j == 6'd1) begin
         w_act = r_inst_sh;
      end
   end

   assign w_diff        = w_cmp_vld && (gold_rdata != w_act);
   assign w_first       = w_diff && !r_mismatch;
   assign w_rec_cnt_inc = r_rec_cnt + 16'd1;

   assign gold_addr = ((r_state == StCmp) && (r_k < KLast)) ? r_rec_base + GOLD_AW'(r_k) : '0;
   assign dbg_raddr = ((r_state == StCmp) && (r_k >= 6'd3)) ? 5'(r_k - 6'd3) : 5'd0;

   assign hold     = r_hold;
   assign rec_cnt  = r_rec_cnt;
   assign done     = (r_state == StDone);
   assign mismatch = r_mismatch;
   assign fail_rec = r_fail_rec;
   assign fail_idx = r_fail_idx;
   assign fail_exp = r_fail_exp;
   assign fail_act = r_fail_act;

   always_comb begin
      w_state_d    = r_state;
      w_k_d        = r_k;
      w_hold_d     = r_hold;
      w_rec_base_d = r_rec_base;
      w_rec_cnt_d  = r_rec_cnt;
      unique case (r_state)
         StIdle: begin
            if (w_start) begin
               w_state_d = StCmp;
               w_k_d     = 6'd0;
               w_hold_d  = 1'b1;
            end
         end
         StCmp: begin
            if (r_k == KLast) begin
`ifdef TRACE_CHK_STOP_ON_FAIL_EN
               if (r_mismatch || w_diff) begin
                  w_state_d = StFail;
               end else
`endif
               begin
                  w_rec_cnt_d  = w_rec_cnt_inc;
                  w_rec_base_d = r_rec_base + GOLD_AW'(KLast);
                  w_hold_d     = 1'b0;
                  w_state_d    = (w_rec_cnt_inc == RecLimit) ? StDone : StIdle;
               end
            end else begin
               w_k_d = r_k + 6'd1;
            end
         end
         StDone: begin
            w_hold_d = 1'b0;
         end
`ifdef TRACE_CHK_STOP_ON_FAIL_EN
         StFail: begin
            w_hold_d = 1'b1;
         end
`endif
         default: begin
            w_state_d = StIdle;
            w_hold_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_k        <= 6'd0;
         r_hold     <= 1'b0;
         r_rec_base <= '0;
         r_rec_cnt  <= 16'd0;
         r_pc_sh    <= 32'd0;
         r_inst_sh  <= 32'd0;
         r_mismatch <= 1'b0;
         r_fail_rec <= 16'd0;
         r_fail_idx <= 6'd0;
         r_fail_exp <= 32'd0;
         r_fail_act <= 32'd0;
      end else begin
         r_k        <= w_k_d;
         r_hold     <= w_hold_d;
         r_rec_base <= w_rec_base_d;
         r_rec_cnt  <= w_rec_cnt_d;
         if (w_start) begin
            r_pc_sh   <= pc;
            r_inst_sh <= inst;
         end
         if (w_first) begin
            r_mismatch <= 1'b1;
            r_fail_rec <= r_rec_cnt;
            r_fail_idx <= w_j;
            r_fail_exp <= gold_rdata;
            r_fail_act <= w_act;
         end
      end
   end

endmodule

// File: doc/cpu_trace_checker.md
# cpu_trace_checker

Synthesizable golden-trace checker for the single-cycle CPU in `sccomp_dataflow`. It consumes a commit stream from the CPU: one record per retired instruction, containing pc, instr, and regfile0..regfile31. It compares each record against a pre-loaded golden trace ROM, with one 34-word record per instruction in exactly that field order. While it sweeps the register file through a debug read port, it stalls the CPU. It latches the first mismatch for readout.

## Interface
Parameters:
- `NUM_RECS`, 1024: number of golden records; checking stops after this many.
- `GOLD_AW`, 16: golden ROM word-address width.

Ports:
- `clk_in` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `chk_en` in 1: check enable; sampled only in IDLE.
- `commit` in 1: CPU retires an instruction this cycle; `pc`/`inst` valid.
- `pc` in 32: pc of the retiring instruction.
- `inst` in 32: instruction word of the retiring instruction.
- `hold` out 1: registered; CPU must not advance while high.
- `dbg_raddr` out 5: combinational regfile debug read address.
- `dbg_rdata` in 32: regfile data, combinational from `dbg_raddr`.
- `gold_addr` out GOLD_AW: golden ROM address.
- `gold_rdata` in 32: golden ROM data, one-cycle synchronous latency.
- `rec_cnt` out 16: number of records fully compared.
- `done` out 1: `rec_cnt == NUM_RECS`.
- `mismatch` out 1: sticky; set on first failing word.
- `fail_rec` out 16: record index of the first mismatch.
- `fail_idx` out 6: field of the first mismatch; 0 = pc, 1 = instr, 2..33 = regfile0..31.
- `fail_exp` out 32: golden value of the first mismatch.
- `fail_act` out 32: observed value of the first mismatch.

## Operation
- States:
  - IDLE: waiting for a commit.
  - CMP: 35-cycle sweep, counter `k` = 0..34.
  - DONE: all records checked.
  - FAIL: entered only when the macro below is defined.
- IDLE to CMP:
  - Condition: `commit & chk_en & !done`.
  - Latch `pc` and `inst` into shadow registers.
  - Set `hold` to 1 and `k` to 0.
- In CMP, at cycle `k`:
  - `gold_addr = rec_base + k` for `k` < 34.
  - `dbg_raddr = k-3` for 3 ≤ `k` ≤ 34; 0 otherwise.
  - For `k` ≥ 1, compare golden word `j = k-1` (`gold_rdata`) against the actual value: shadow pc for j=0, shadow inst for j=1, `dbg_rdata` for j≥2.
- Regfile0 is compared like every other register; golden value must be 0.
- End of sweep, at `k` = 34:
  - `rec_cnt` increments.
  - `rec_base` increments by 34, modulo 2^GOLD_AW.
  - `hold` clears and the FSM returns to IDLE.
  - If the new `rec_cnt` equals `NUM_RECS`, the FSM goes to DONE instead.
- Mismatch handling:
  - The first differing word sets `mismatch`.
  - The same cycle captures `fail_rec` = `rec_cnt`, `fail_idx` = j, `fail_exp`, and `fail_act`.
  - Later mismatches never overwrite the captured fields.
- DONE:
  - `done` = 1, `hold` = 0.
  - Commits are ignored; the state holds until reset.
- Other rules:
  - `commit` while `hold` = 1 is a CPU protocol violation and is ignored.
  - `chk_en` falling during CMP does not abort; the current record completes.

## Timing
- Reset values: every output is 0, including `hold`, `gold_addr`, `dbg_raddr`, `rec_cnt`, `done`, `mismatch`, and all `fail_*` fields. Also `rec_base` = 0 and state = IDLE.
- Reset asserted mid-CMP: asynchronous return to all reset values; the partial record is discarded and not counted.
- `hold` rises on the clock edge that samples `commit`. It stays high for exactly 35 cycles, so the CPU stalls 35 cycles per instruction.
- Register values compared are the post-writeback state of the committing instruction.
- `mismatch` is visible the cycle after the compare of the failing word.
- `rec_cnt` and `done` update on the same edge at which `hold` falls.
- `gold_addr` wraps silently when `NUM_RECS`·34 > 2^GOLD_AW.

## Configuration
- `TRACE_CHK_STOP_ON_FAIL_EN`:
  - Defined: the first mismatch moves the FSM to FAIL at the end of the current sweep. In FAIL, `hold` = 1 permanently (CPU frozen for inspection) and `rec_cnt` does not increment for the failing record. Only reset exits FAIL.
  - Undefined: no FAIL state; checking continues through all records and `mismatch` remains a sticky flag.

## Test plan
- Reset then idle: `reset` low 3 cycles, no `commit` → all outputs 0, `hold` stays 0.
- Single good record: ROM rec 0 = {0x00400000, 0x20010005, regs with r1 = 5, others 0}; regfile matches; commit with `pc` = 0x00400000 → `hold` high exactly 35 cycles, `rec_cnt` = 1, `mismatch` = 0.
- Register mismatch: as previous, but r9 = 0x12 while golden r9 = 0x13 → `mismatch` = 1, `fail_rec` = 0, `fail_idx` = 11, `fail_exp` = 0x13, `fail_act` = 0x12. Check with and without `TRACE_CHK_STOP_ON_FAIL_EN` (frozen `hold` vs. `rec_cnt` = 1).
- pc mismatch in the 3rd record, then later mismatches → `fail_idx` = 0, `fail_rec` = 2; fields unchanged after later failures.
- End of trace: `NUM_RECS` = 2, three commits → `done` = 1 after the second, third commit ignored, `hold` = 0, `rec_cnt` = 2.
- Reset mid-sweep at `k` = 17 → all outputs 0; next commit reads `gold_addr` starting at 0.
